// File: rtl/bcd_score_tracker.sv
// bcd_score_tracker: packed-BCD game score with clamped variable step, floored
// penalty, saturation at all 9s, per-game clear and a persistent high score.
module bcd_score_tracker #(
    parameter int DIGITS   = 4,
    parameter int STEP_MAX = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    input  logic [3:0]            step,
    input  logic                  dec,
    input  logic                  clear_game,
    output logic [4*DIGITS-1:0]   score,
    output logic [4*DIGITS-1:0]   high_score,
    output logic                  saturated,
    output logic                  new_high
);
    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ALL9 = {DIGITS{4'h9}};
    localparam logic [3:0] SMAX = 4'(STEP_MAX);

    logic [W-1:0] score_q, score_d, high_q, high_d, sum, diff;
    logic         sat_q, sat_d, nh_q, nh_d, carry, borrow;
    logic [3:0]   eff;
    logic [4:0]   t;

    always_comb begin
        eff    = (step > SMAX) ? SMAX : step;
        carry  = 1'b0;
        borrow = 1'b1;
        sum    = '0;
        diff   = '0;
        t      = '0;
        // decimal carry and borrow ripple across all digits in one cycle
        for (int i = 0; i < DIGITS; i++) begin
            t = {1'b0, score_q[4*i +: 4]} + {4'd0, carry} + ((i == 0) ? {1'b0, eff} : 5'd0);
            carry = t > 5'd9;
            sum[4*i +: 4] = carry ? 4'(t - 5'd10) : t[3:0];
            diff[4*i +: 4] = !borrow ? score_q[4*i +: 4] :
                             (score_q[4*i +: 4] == 4'd0) ? 4'd9 : score_q[4*i +: 4] - 4'd1;
            borrow = borrow && (score_q[4*i +: 4] == 4'd0);
        end
        score_d = clear_game ? '0 :
                  inc        ? (carry ? ALL9 : sum) :
                  dec        ? ((score_q == '0) ? '0 : diff) : score_q;
        // valid BCD orders the same as binary, so a plain compare is MSD-first
        nh_d   = score_d > high_q;
        high_d = nh_d ? score_d : high_q;
        sat_d  = score_d == ALL9;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_q <= '0;
            high_q  <= '0;
            sat_q   <= 1'b0;
            nh_q    <= 1'b0;
        end else begin
            score_q <= score_d;
            high_q  <= high_d;
            sat_q   <= sat_d;
            nh_q    <= nh_d;
        end
    end

    assign score      = score_q;
    assign high_score = high_q;
    assign saturated  = sat_q;
    assign new_high   = nh_q;
endmodule

// File: tb/tb_bcd_score_tracker.sv
// tb_bcd_score_tracker: vector table, hand-written corner sequences and a
// randomized run against an integer-arithmetic score model.
module tb_bcd_score_tracker;
    logic        clk = 1'b0, rst = 1'b0, inc = 1'b0, dec = 1'b0, clear_game = 1'b0;
    logic [3:0]  step = 4'd0;
    logic [15:0] score, high_score;
    logic        saturated, new_high;
    int tests = 0, fails = 0;
    int ms = 0, mh = 0;
    bit mnh = 0;

    typedef struct {
        bit i; logic [3:0] s; bit d; bit c;
        logic [15:0] sc; logic [15:0] hs; bit sat; bit nh;
    } vec_t;
    vec_t tbl[$];

    bcd_score_tracker #(.DIGITS(4), .STEP_MAX(9)) dut (
        .clk(clk), .rst(rst), .inc(inc), .step(step), .dec(dec), .clear_game(clear_game),
        .score(score), .high_score(high_score), .saturated(saturated), .new_high(new_high)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic vec_t mk(input bit i, input logic [3:0] s, input bit d, input bit c,
                                input logic [15:0] sc, input logic [15:0] hs, input bit sat, input bit nh);
        vec_t x;
        x.i = i; x.s = s; x.d = d; x.c = c; x.sc = sc; x.hs = hs; x.sat = sat; x.nh = nh;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic model(input bit i, input logic [3:0] s, input bit d, input bit c);
        int e;
        e = (s > 9) ? 9 : int'(s);
        if (c) ms = 0;
        else if (i) ms = (ms + e > 9999) ? 9999 : ms + e;
        else if (d && ms > 0) ms = ms - 1;
        mnh = ms > mh;
        if (mnh) mh = ms;
    endtask

    task automatic cyc(input bit i, input logic [3:0] s, input bit d, input bit c);
        inc = i; step = s; dec = d; clear_game = c;
        @(posedge clk); #1;
        model(i, s, d, c);
        inc = 0; step = 0; dec = 0; clear_game = 0;
    endtask

    task automatic add(input int n, input logic [3:0] r);
        repeat (n) cyc(1, 9, 0, 0);
        if (r != 0) cyc(1, r, 0, 0);
    endtask

    task automatic do_reset();
        #2 rst = 1; #3 rst = 0;
        ms = 0; mh = 0; mnh = 0;
    endtask

    task automatic chk_all(input string nm, input logic [15:0] sc, input logic [15:0] hs, input bit sat, input bit nh);
        chk({nm, " score"}, score, sc);
        chk({nm, " high"}, high_score, hs);
        chk({nm, " sat"}, saturated, sat);
        chk({nm, " new_high"}, new_high, nh);
    endtask

    initial begin
        for (int k = 1; k <= 12; k++)
            tbl.push_back(mk(1, 1, 0, 0, 16'(k < 10 ? k : k + 6), 16'(k < 10 ? k : k + 6), 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 16'h0011, 16'h0012, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 16'h0010, 16'h0012, 0, 0));
        tbl.push_back(mk(1, 2, 1, 0, 16'h0012, 16'h0012, 0, 0));
        tbl.push_back(mk(1, 15, 0, 0, 16'h0021, 16'h0021, 0, 1));
        tbl.push_back(mk(1, 5, 0, 1, 16'h0000, 16'h0021, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0021, 0, 0));
        tbl.push_back(mk(1, 15, 0, 0, 16'h0009, 16'h0021, 0, 0));
        tbl.push_back(mk(1, 15, 0, 0, 16'h0018, 16'h0021, 0, 0));
        tbl.push_back(mk(1, 15, 0, 0, 16'h0027, 16'h0027, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 16'h0027, 16'h0027, 0, 0));

        rst = 1; #12 rst = 0; #1;
        chk_all("reset", 16'h0, 16'h0, 0, 0);

        foreach (tbl[n]) begin
            cyc(tbl[n].i, tbl[n].s, tbl[n].d, tbl[n].c);
            chk_all($sformatf("vec%0d", n), tbl[n].sc, tbl[n].hs, tbl[n].sat, tbl[n].nh);
        end

        do_reset();
        add(110, 8);
        chk("preload 998", score, 16'h0998);
        cyc(1, 5, 0, 0); chk_all("carry3", 16'h1003, 16'h1003, 0, 1);
        cyc(0, 0, 1, 0); chk("dec 1002", score, 16'h1002);
        cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
        chk("dec 1000", score, 16'h1000);
        cyc(0, 0, 1, 0); chk_all("borrow3", 16'h0999, 16'h1003, 0, 0);

        add(999, 5);
        chk("preload 9995", score, 16'h9995);
        cyc(1, 9, 0, 0); chk_all("saturate", 16'h9999, 16'h9999, 1, 1);
        cyc(1, 3, 0, 0); chk_all("sat hold", 16'h9999, 16'h9999, 1, 0);
        cyc(0, 0, 1, 0); chk_all("sat dec", 16'h9998, 16'h9999, 0, 0);
        cyc(1, 1, 0, 0); chk("resat", saturated, 1'b1);
        cyc(0, 0, 0, 1); chk_all("sat clear", 16'h0000, 16'h9999, 0, 0);

        do_reset();
        add(4, 4);
        chk("preload 40", score, 16'h0040);
        cyc(0, 0, 0, 1); chk_all("clear", 16'h0000, 16'h0040, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 15, 0, 0);
            chk($sformatf("clamp nh%0d", k), new_high, 1'b0);
        end
        chk_all("clamp", 16'h0027, 16'h0040, 0, 0);

        do_reset();
        add(55, 5);
        chk_all("preload 500", 16'h0500, 16'h0500, 0, 1);
        #2 rst = 1; #1;
        chk_all("async rst", 16'h0, 16'h0, 0, 0);
        rst = 0; ms = 0; mh = 0; mnh = 0;
        cyc(1, 1, 0, 0); chk_all("post rst", 16'h0001, 16'h0001, 0, 1);

        for (int n = 0; n < 4000; n++) begin
            bit c, i, d;
            c = ($urandom_range(0, 127) == 0);
            i = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 2) == 0);
            cyc(i, 4'($urandom_range(0, 15)), d, c);
            chk($sformatf("rand%0d", n), {score, high_score, saturated, new_high},
                {to_bcd(ms), to_bcd(mh), ms == 9999, mnh});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bcd_score_tracker.md
Name: bcd_score_tracker

Overview:
- Parametrised BCD score keeper for game logic; successor to the fixed 4-digit +1 score counter.
- Adds a variable step per event, a penalty decrement with floor at zero, saturation status, a per-game clear and a persistent high-score register.
- Sits between the game FSM (event pulses) and the seven-segment display driver, which consumes packed BCD nibbles.

Parameters:
- DIGITS, 4, number of BCD digits; score width is 4*DIGITS; legal range 1..8.
- STEP_MAX, 9, largest honoured step value; larger step inputs clamp to STEP_MAX; legal range 1..9.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- inc  in  1  single-cycle scoring event.
- step  in  4  binary amount added to the score on inc; sampled only when inc=1.
- dec  in  1  single-cycle penalty event; subtracts 1.
- clear_game  in  1  synchronous score clear; the high score is kept.
- score  out  4*DIGITS  packed BCD score; digit 0 is in bits [3:0].
- high_score  out  4*DIGITS  packed BCD best score since rst.
- saturated  out  1  level; high while score is all 9s.
- new_high  out  1  one-cycle pulse when high_score increases.

Behaviour:
- Reset (async, rst=1): score=0, high_score=0, saturated=0, new_high=0. All outputs are registered.
- Clock is one cycle per event: an event sampled at edge N is visible on score after edge N.
- Priority per cycle: clear_game > inc > dec > hold.
  - When inc and dec are both asserted, dec is dropped with no effect.
- inc:
  - eff_step = min(step, STEP_MAX); step=0 leaves score unchanged.
  - The score gets a BCD add of eff_step to digit 0, with decimal carry rippling through all DIGITS digits within the same cycle.
  - Every digit stays in 0..9 at all times.
- Saturation: if the exact sum exceeds the all-9s value (10^DIGITS - 1), score is set to all 9s. There is no wrap.
- dec:
  - Score 0 stays 0 (floor).
  - Otherwise BCD subtract 1 with decimal borrow, e.g. 1000 -> 0999.
- clear_game: score <= 0 and saturated <= 0. high_score is unchanged, and new_high is 0 in that cycle.
- saturated is registered and equals (score == all 9s) for the registered score value. It is driven by the same edge that updates score, with no extra latency.
- High score:
  - Each edge compares the next score value against the current high_score.
  - If next > high_score (BCD compare, most significant digit first), high_score <= next and new_high <= 1. Otherwise high_score holds and new_high <= 0.
  - high_score therefore tracks score on the same edge, and new_high is asserted in the cycle in which the new score is first visible.
- Once saturated, further inc events hold score at all 9s and leave new_high at 0 (equal, not greater).
- rst asserted mid-event overrides everything immediately, without waiting for a clock edge. The first event after deassertion is accepted on the first rising edge with rst=0.
- Input digit legality: step is binary 0..15. It is clamped before the add, so no illegal BCD value is ever produced.

Test Plan (DIGITS=4, STEP_MAX=9):
1. Reset, then 12 inc pulses with step=1 -> score=0x0012, high_score=0x0012, new_high high on every one of the 12 cycles, saturated=0.
2. Preload score 0x0998 via increments, then inc step=5 -> score=0x1003 after one edge (carry through three digits). Then dec -> 0x1002. Dec from 0x1000 -> 0x0999.
3. From score 0x9995, inc step=9 -> score=0x9999 and saturated=1. A further inc step=3 -> score stays 0x9999, new_high=0. Then dec -> 0x9998, saturated=0.
4. Score 0x0040, then clear_game -> score=0, high_score=0x0040, new_high=0. Next, 3 inc step=15 (clamped to 9) -> score=0x0027, high_score=0x0040, new_high never pulses.
5. Same-cycle inc(step=2)+dec at score 0x0010 -> 0x0012. Same-cycle clear_game+inc -> score=0. Dec at score 0 -> score stays 0.
6. rst pulse asserted asynchronously between clock edges at score 0x0500 -> score, high_score and flags are 0 before the next edge. An inc on the first edge after release -> score 0x0001.
